// File: rtl/tanh_operand_feeder_if.sv
// rtl/tanh_operand_feeder_if.sv - host/core handshake bundle for the tanh operand feeder
// err_timeout exists only when FEEDER_TIMEOUT_EN is defined.
interface tanh_operand_feeder_if #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 4
);
  localparam int LVL_W = $clog2(DEPTH) + 1;

  logic [DATA_W-1:0] in_data;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] core_x;
  logic              core_start;
  logic              core_ready;
  logic [DATA_W-1:0] core_y;
  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              out_ack;
  logic [LVL_W-1:0]  level;
`ifdef FEEDER_TIMEOUT_EN
  logic              err_timeout;
`endif

  // master: host plus core side (drives operands, core result and acks)
  modport master (
    output in_data, in_valid, core_ready, core_y, out_ack,
    input  in_ready, core_x, core_start, out_data, out_valid, level
`ifdef FEEDER_TIMEOUT_EN
    , input err_timeout
`endif
  );

  modport slave (
    input  in_data, in_valid, core_ready, core_y, out_ack,
    output in_ready, core_x, core_start, out_data, out_valid, level
`ifdef FEEDER_TIMEOUT_EN
    , output err_timeout
`endif
  );
endinterface

// File: rtl/tanh_operand_feeder.sv
// rtl/tanh_operand_feeder.sv - operand FIFO and start/ready job sequencer for the tanh core
// Optional FEEDER_TIMEOUT_EN adds a wait-for-core timeout with a sticky err_timeout flag.
module tanh_operand_feeder #(
  parameter int DATA_W         = 16,
  parameter int DEPTH          = 4,
  parameter int START_CYCLES   = 2,
  parameter int TIMEOUT_CYCLES = 1023
) (
  input  logic                 clock,
  input  logic                 reset,
  tanh_operand_feeder_if.slave bus
);
  localparam int PTR_W  = $clog2(DEPTH);
  localparam int LVL_W  = PTR_W + 1;
  localparam int SCNT_W = $clog2(START_CYCLES + 1);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("DEPTH must be a power of 2 and >= 2");
  end
  if (START_CYCLES < 1) begin : g_bad_start
    $error("START_CYCLES must be >= 1");
  end
  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be >= 1");
  end

  typedef enum logic [2:0] {IDLE, START, WAIT_BUSY, WAIT_DONE, HOLD} state_t;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
  logic [LVL_W-1:0]  level_q, level_d;

  state_t            state_q;
  logic [SCNT_W-1:0] scnt_q;
  logic              seen_busy_q;
  logic [DATA_W-1:0] core_x_q;
  logic              core_start_q;
  logic [DATA_W-1:0] out_data_q;
  logic              out_valid_q;

  logic push, pop;

  // both decisions use the registered level, so a pop never frees a slot in the same cycle
  assign push = bus.in_valid && (level_q != LVL_W'(DEPTH));
  assign pop  = (state_q == IDLE) && (level_q != '0) && !out_valid_q;

  always_comb begin
    level_d = level_q;
    case ({push, pop})
      2'b10:   level_d = level_q + LVL_W'(1);
      2'b01:   level_d = level_q - LVL_W'(1);
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clock) begin
    if (push) mem_q[wr_ptr_q] <= bus.in_data;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      level_q <= level_d;
    end
  end

`ifdef FEEDER_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TMO_W-1:0] tmo_q;
  logic             err_q;
  logic             tmo_hit;
  assign tmo_hit = (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1));
  assign bus.err_timeout = err_q;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= IDLE;
      scnt_q       <= '0;
      seen_busy_q  <= 1'b0;
      core_x_q     <= '0;
      core_start_q <= 1'b0;
      out_data_q   <= '0;
      out_valid_q  <= 1'b0;
`ifdef FEEDER_TIMEOUT_EN
      tmo_q        <= '0;
      err_q        <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (pop) begin
            core_x_q     <= mem_q[rd_ptr_q];
            core_start_q <= 1'b1;
            scnt_q       <= '0;
            seen_busy_q  <= 1'b0;
            state_q      <= START;
          end
        end
        START: begin
          // the core may drop ready while start is still high; remember it
          if (!bus.core_ready) seen_busy_q <= 1'b1;
          if (scnt_q == SCNT_W'(START_CYCLES - 1)) begin
            core_start_q <= 1'b0;
            state_q      <= (seen_busy_q || !bus.core_ready) ? WAIT_DONE : WAIT_BUSY;
`ifdef FEEDER_TIMEOUT_EN
            tmo_q        <= '0;
`endif
          end else begin
            scnt_q <= scnt_q + SCNT_W'(1);
          end
        end
        WAIT_BUSY: begin
          if (!bus.core_ready) state_q <= WAIT_DONE;
`ifdef FEEDER_TIMEOUT_EN
          if (tmo_hit) begin
            err_q   <= 1'b1;
            state_q <= IDLE;
          end else begin
            tmo_q <= tmo_q + TMO_W'(1);
          end
`endif
        end
        WAIT_DONE: begin
          if (bus.core_ready) begin
            out_data_q  <= bus.core_y;
            out_valid_q <= 1'b1;
            state_q     <= HOLD;
          end
`ifdef FEEDER_TIMEOUT_EN
          else if (tmo_hit) begin
            err_q   <= 1'b1;
            state_q <= IDLE;
          end else begin
            tmo_q <= tmo_q + TMO_W'(1);
          end
`endif
        end
        HOLD: begin
          if (bus.out_ack) begin
            out_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.in_ready   = (level_q != LVL_W'(DEPTH));
  assign bus.level      = level_q;
  assign bus.core_x     = core_x_q;
  assign bus.core_start = core_start_q;
  assign bus.out_data   = out_data_q;
  assign bus.out_valid  = out_valid_q;
endmodule

// File: tb/tb_tanh_operand_feeder.sv
// tb/tb_tanh_operand_feeder.sv - directed bench for tanh_operand_feeder with a 48-cycle core stub
// Core stub returns Y = ~X; FEEDER_TIMEOUT_EN enables the timeout scenario.
module tb_tanh_operand_feeder;
  localparam int DATA_W = 16;
  localparam int DEPTH  = 4;
  localparam int LAT    = 48;
`ifdef FEEDER_TIMEOUT_EN
  localparam int TMO = 100;
`else
  localparam int TMO = 1023;
`endif

  logic clock;
  logic reset;
  int   n_tests = 0;
  int   n_fail  = 0;

  tanh_operand_feeder_if #(.DATA_W(DATA_W), .DEPTH(DEPTH)) bus ();

  tanh_operand_feeder #(
    .DATA_W(DATA_W), .DEPTH(DEPTH), .START_CYCLES(2), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  initial begin
    clock = 1'b0;
    forever #30 clock = ~clock;
  end

  // core stub: ready drops on start, returns LAT cycles later with ~X; hang mode never returns
  logic              stub_ready, stub_busy, stub_hang;
  logic [DATA_W-1:0] stub_x, stub_y;
  int                stub_cnt;

  always @(posedge clock) begin
    if (reset) begin
      stub_ready <= 1'b1;
      stub_busy  <= 1'b0;
      stub_x     <= '0;
      stub_y     <= '0;
      stub_cnt   <= 0;
    end else if (!stub_busy && bus.core_start) begin
      stub_busy  <= 1'b1;
      stub_ready <= 1'b0;
      stub_x     <= bus.core_x;
      stub_cnt   <= LAT;
    end else if (stub_busy && !stub_hang) begin
      if (stub_cnt == 1) begin
        stub_ready <= 1'b1;
        stub_y     <= ~stub_x;
        stub_busy  <= 1'b0;
      end
      stub_cnt <= stub_cnt - 1;
    end
  end

  assign bus.core_ready = stub_ready;
  assign bus.core_y     = stub_y;

  int   x_glitch = 0;
  int   start_count = 0;
  logic start_prev = 1'b0;

  always @(negedge clock) begin
    if (stub_busy && bus.core_x != stub_x) x_glitch <= x_glitch + 1;
    if (reset) start_count <= 0;
    else if (bus.core_start && !start_prev) start_count <= start_count + 1;
    start_prev <= bus.core_start;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic wait_valid(input string tag, input int max);
    int n = 0;
    while (!bus.out_valid && n < max) begin
      @(negedge clock);
      n++;
    end
    check(tag, 32'(bus.out_valid), 32'd1);
  endtask

  task automatic ack(input string tag);
    bus.out_ack = 1'b1;
    @(negedge clock);
    bus.out_ack = 1'b0;
    check(tag, 32'(bus.out_valid), 32'd0);
  endtask

  task automatic push(input logic [DATA_W-1:0] d);
    bus.in_data  = d;
    bus.in_valid = 1'b1;
    @(negedge clock);
    bus.in_valid = 1'b0;
  endtask

  logic [DATA_W-1:0] t2_ops [3];
  logic [DATA_W-1:0] t2_exp [3];
  logic [DATA_W-1:0] t3_exp [5];

  initial begin
    int n;
    t2_ops = '{16'h4000, 16'h1111, 16'h0422};
    t2_exp = '{16'hBFFF, 16'hEEEE, 16'hFBDD};
    t3_exp = '{16'hFDFD, 16'hFCFC, 16'hFBFB, 16'hFAFA, 16'hF7F7};

    reset        = 1'b1;
    bus.in_data  = '0;
    bus.in_valid = 1'b0;
    bus.out_ack  = 1'b0;
    stub_hang    = 1'b0;
    repeat (2) @(negedge clock);
    reset = 1'b0;

    check("rst_level",    32'(bus.level),      32'd0);
    check("rst_in_ready", 32'(bus.in_ready),   32'd1);
    check("rst_core_x",   32'(bus.core_x),     32'd0);
    check("rst_start",    32'(bus.core_start), 32'd0);
    check("rst_out_data", 32'(bus.out_data),   32'd0);
    check("rst_out_valid",32'(bus.out_valid),  32'd0);

    // 1: single job
    push(16'h4000);
    check("t1_level_push", 32'(bus.level), 32'd1);
    @(negedge clock);
    check("t1_level_pop", 32'(bus.level),      32'd0);
    check("t1_core_x",    32'(bus.core_x),     32'h4000);
    check("t1_start",     32'(bus.core_start), 32'd1);
    n = 0;
    while (bus.core_start && n < 10) begin
      n++;
      @(negedge clock);
    end
    check("t1_start_len",  32'(n), 32'd2);
    check("t1_core_busy",  32'(bus.core_ready), 32'd0);
    wait_valid("t1_valid", 100);
    check("t1_out_data", 32'(bus.out_data), 32'hBFFF);
    repeat (3) @(negedge clock);
    check("t1_valid_held", 32'(bus.out_valid), 32'd1);
    ack("t1_ack");

    // 2: three back-to-back operands, results in order
    for (int i = 0; i < 3; i++) begin
      bus.in_data  = t2_ops[i];
      bus.in_valid = 1'b1;
      @(negedge clock);
    end
    bus.in_valid = 1'b0;
    check("t2_level", 32'(bus.level), 32'd2);
    for (int i = 0; i < 3; i++) begin
      wait_valid("t2_valid", 200);
      check("t2_out_data", 32'(bus.out_data), 32'(t2_exp[i]));
      check("t2_core_x",   32'(bus.core_x),   32'(t2_ops[i]));
      repeat (3) @(negedge clock);
      ack("t2_ack");
    end
    check("t2_x_stable", 32'(x_glitch), 32'd0);

    // 3/6: overfill without acks, then pop/push collisions at full
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    for (int i = 0; i < 6; i++) begin
      bus.in_data  = 16'(16'h0101 * (i + 1));
      bus.in_valid = 1'b1;
      @(negedge clock);
      if (i == 1) begin
        check("t3_level_pushpop", 32'(bus.level),      32'd1);
        check("t3_start",         32'(bus.core_start), 32'd1);
      end
    end
    bus.in_valid = 1'b0;
    check("t3_level_full", 32'(bus.level),    32'd4);
    check("t3_in_ready",   32'(bus.in_ready), 32'd0);
    repeat (60) @(negedge clock);
    check("t3_valid",      32'(bus.out_valid), 32'd1);
    check("t3_out_data",   32'(bus.out_data),  32'hFEFE);
    check("t3_one_job",    32'(start_count),   32'd1);
    check("t3_level_hold", 32'(bus.level),     32'd4);
    ack("t3_ack0");
    push(16'h0707);
    check("t6_level_drop", 32'(bus.level),  32'd3);
    check("t6_core_x",     32'(bus.core_x), 32'h0202);
    push(16'h0808);
    check("t6_level_refill", 32'(bus.level), 32'd4);
    for (int i = 0; i < 5; i++) begin
      wait_valid("t6_valid", 200);
      check("t6_out_data", 32'(bus.out_data), 32'(t3_exp[i]));
      ack("t6_ack");
    end
    check("t6_level_empty", 32'(bus.level), 32'd0);

    // 4: reset while waiting for the core
    push(16'h1234);
    repeat (20) @(negedge clock);
    check("t4_mid_job", 32'(bus.core_ready), 32'd0);
    reset = 1'b1;
    @(negedge clock);
    check("t4_start",     32'(bus.core_start), 32'd0);
    check("t4_out_valid", 32'(bus.out_valid),  32'd0);
    check("t4_level",     32'(bus.level),      32'd0);
    check("t4_core_x",    32'(bus.core_x),     32'd0);
    check("t4_out_data",  32'(bus.out_data),   32'd0);
    check("t4_in_ready",  32'(bus.in_ready),   32'd1);
    reset = 1'b0;
    repeat (70) @(negedge clock);
    check("t4_no_stale", 32'(bus.out_valid), 32'd0);
    check("t4_no_job",   32'(start_count),   32'd0);

`ifdef FEEDER_TIMEOUT_EN
    // 5: core never answers
    check("t5_err_rst", 32'(bus.err_timeout), 32'd0);
    stub_hang = 1'b1;
    push(16'h5555);
    n = 0;
    while (!bus.core_start && n < 10) begin
      @(negedge clock);
      n++;
    end
    n = 0;
    while (bus.core_start && n < 10) begin
      @(negedge clock);
      n++;
    end
    n = 0;
    while (!bus.err_timeout && n < 300) begin
      @(negedge clock);
      n++;
    end
    check("t5_tmo_cycle", 32'(n),             32'd100);
    check("t5_no_valid",  32'(bus.out_valid), 32'd0);
    stub_hang = 1'b0;
    repeat (60) @(negedge clock);
    push(16'h00FF);
    wait_valid("t5_valid", 200);
    check("t5_out_data", 32'(bus.out_data),    32'hFF00);
    ack("t5_ack");
    check("t5_sticky",   32'(bus.err_timeout), 32'd1);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #(60 * 20000);
    $display("FAIL watchdog: simulation exceeded 20000 cycles");
    $fatal(1);
  end
endmodule
